victim_buffer_control: RTL and testbench
========================================

VICTIM_BUFFER_CONTROL -- requirements
Module: victim_buffer_control

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_WAYS, 4, fully-associative entries (power of 2, >=2); TAG_WIDTH, 27, line-address width; LINE_WIDTH, 256, line data width.
REQ-002 Ports SHALL be (name direction width meaning); one clock; reset is asynchronous and active-high: clk in 1 clock; rst in 1 reset.
REQ-003 swap_req in 1 L1 miss/eviction swap request; swap_tag in TAG_WIDTH requested line address.
REQ-004 evict_valid in 1, evict_dirty in 1, evict_tag in TAG_WIDTH, evict_data in LINE_WIDTH: the line L1 hands over.
REQ-005 swap_resp out 1 one-cycle completion; swap_hit out 1 data came from buffer; swap_data out LINE_WIDTH returned line.
REQ-006 pmem_read out 1; pmem_write out 1; pmem_addr out TAG_WIDTH; pmem_wdata out LINE_WIDTH; pmem_rdata in LINE_WIDTH; pmem_resp in 1.
REQ-007 hit_count, miss_count, wb_count out 32 each: statistics.

Function
REQ-008 Each way SHALL hold valid, dirty, tag, data, and a log2(NUM_WAYS)-bit age.
REQ-009 States SHALL be IDLE, LOOKUP, WRITEBACK, FETCH, RESP.
REQ-010 IDLE: swap_req high registers swap_tag and all evict_* fields -> LOOKUP; pmem_resp ignored.
REQ-011 LOOKUP: registered tag compared against all valid ways; hit (at most one way) -> RESP with swap_hit=1, swap_data=way data.
REQ-012 LOOKUP miss: victim = lowest-index invalid way, else way with age NUM_WAYS-1; victim valid and dirty -> WRITEBACK, else -> FETCH.
REQ-013 WRITEBACK: pmem_write=1, pmem_addr=victim tag, pmem_wdata=victim data held stable; pmem_resp -> FETCH.
REQ-014 FETCH: pmem_read=1, pmem_addr=registered request tag; pmem_resp captures pmem_rdata into swap_data -> RESP.
REQ-015 RESP: swap_resp=1 for exactly one cycle, swap_data/swap_hit stable; target way (hit way or victim) loaded with registered evict line if evict_valid, else invalidated; -> IDLE.
REQ-016 Installed way SHALL get age 0; ways with age below its old age increment; invalidation leaves ages unchanged; ages remain a permutation of 0..NUM_WAYS-1.
REQ-017 Latency: hit, swap_resp 2 cycles after swap_req sampled; miss, 2 cycles plus pmem wait cycles.
REQ-018 Requester SHALL hold swap_req and inputs stable until swap_resp and drop swap_req the following cycle; input changes after IDLE sampling have no effect.
REQ-019 pmem_read and pmem_write SHALL never be high together; both low outside FETCH/WRITEBACK.
REQ-020 Evict tag equal to a resident tag is a requester error; behaviour unspecified, no check.

Reset
REQ-021 rst SHALL asynchronously force IDLE, clear all valid/dirty bits, set way i age to i, zero all outputs and counters.
REQ-022 rst mid-WRITEBACK/FETCH SHALL drop pmem_read/pmem_write immediately and abandon the transaction with no swap_resp.

Configuration
REQ-023 With VICTIM_BUFFER_STATS_EN defined, hit_count increments on LOOKUP hit, miss_count on LOOKUP miss, wb_count on WRITEBACK entry, each saturating at 2^32-1.
REQ-024 Without VICTIM_BUFFER_STATS_EN, counter ports SHALL remain present and tied to zero, with no counter logic.

Structure
REQ-025 Package victim_buffer_pkg SHALL hold the state enum, default parameter constants, and line/tag typedefs.
REQ-026 Age update SHALL live in sub-module victim_lru (NUM_WAYS parameter; touch-way input; LRU-way output).

Verification
REQ-027 Reset, then swap_req tag 0x10, evict clean tag 0x20: FETCH at pmem_addr 0x10; pmem_resp data 0xAA.. -> swap_resp, swap_hit=0, swap_data 0xAA..; way0 holds 0x20.
REQ-028 Then swap_req tag 0x20, evict tag 0x10: swap_resp exactly 2 cycles later, swap_hit=1, no pmem access.
REQ-029 Fill 4 ways dirty, miss on tag 0x99: pmem_write of LRU tag before pmem_read 0x99; wb_count=1 with stats enabled.
REQ-030 pmem_resp delayed 5 cycles in FETCH: pmem_read held steady 6 cycles, single swap_resp.
REQ-031 rst asserted mid-FETCH: pmem_read low same cycle, no swap_resp, all ways invalid afterwards.

Source files
------------

// File: rtl/victim_buffer_pkg.sv
// Shared types and default sizing for the victim buffer controller.
package victim_buffer_pkg;

  localparam int DEF_NUM_WAYS   = 4;
  localparam int DEF_TAG_WIDTH  = 27;
  localparam int DEF_LINE_WIDTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FETCH,
    RESP
  } state_t;

  typedef logic [DEF_TAG_WIDTH-1:0]  tag_t;
  typedef logic [DEF_LINE_WIDTH-1:0] line_t;

endpackage

// File: rtl/victim_buffer_control_lru.sv
// Age-based LRU tracker: a touched way becomes youngest, younger ways age by one.
module victim_lru #(
  parameter  int NUM_WAYS = 4,
  localparam int IW       = $clog2(NUM_WAYS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          touch,
  input  logic [IW-1:0] touch_way,
  output logic [IW-1:0] lru_way
);

  logic [IW-1:0] age [NUM_WAYS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WAYS; i++) age[i] <= IW'(i);
    end else if (touch) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (i == int'(touch_way))
          age[i] <= '0;
        else if (age[i] < age[touch_way])
          age[i] <= age[i] + 1'b1;
      end
    end
  end

  // Ages stay a permutation, so exactly one way carries the oldest age.
  always_comb begin
    lru_way = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      if (age[i] == IW'(NUM_WAYS - 1)) lru_way = IW'(i);
  end

endmodule

// File: rtl/victim_buffer_control.sv
// Fully-associative victim buffer swap controller with pmem writeback/fetch.
// Optional statistics counters enabled by defining VICTIM_BUFFER_STATS_EN.
module victim_buffer_control
  import victim_buffer_pkg::*;
#(
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  swap_req,
  input  logic [TAG_WIDTH-1:0]  swap_tag,
  input  logic                  evict_valid,
  input  logic                  evict_dirty,
  input  logic [TAG_WIDTH-1:0]  evict_tag,
  input  logic [LINE_WIDTH-1:0] evict_data,
  output logic                  swap_resp,
  output logic                  swap_hit,
  output logic [LINE_WIDTH-1:0] swap_data,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [TAG_WIDTH-1:0]  pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
);

  localparam int IW = $clog2(NUM_WAYS);

  state_t state, state_nxt;

  logic [TAG_WIDTH-1:0]  req_tag, ev_tag;
  logic                  ev_valid, ev_dirty;
  logic [LINE_WIDTH-1:0] ev_data;

  logic [NUM_WAYS-1:0]   way_valid, way_dirty;
  logic [TAG_WIDTH-1:0]  way_tag  [NUM_WAYS];
  logic [LINE_WIDTH-1:0] way_data [NUM_WAYS];

  logic [IW-1:0] target, hit_way, free_way, lru_way, victim;
  logic          hit, has_free, install;

  // Descending scan leaves the lowest-index match/free way as the result.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_valid[i] && (way_tag[i] == req_tag)) begin
        hit     = 1'b1;
        hit_way = IW'(i);
      end
      if (!way_valid[i]) begin
        has_free = 1'b1;
        free_way = IW'(i);
      end
    end
  end

  assign victim = has_free ? free_way : lru_way;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    swap_resp  = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    install    = 1'b0;
    unique case (state)
      IDLE:      if (swap_req) state_nxt = LOOKUP;
      LOOKUP: begin
        if (hit)
          state_nxt = RESP;
        else if (way_valid[victim] && way_dirty[victim])
          state_nxt = WRITEBACK;
        else
          state_nxt = FETCH;
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_addr  = way_tag[target];
        pmem_wdata = way_data[target];
        if (pmem_resp) state_nxt = FETCH;
      end
      FETCH: begin
        pmem_read = 1'b1;
        pmem_addr = req_tag;
        if (pmem_resp) state_nxt = RESP;
      end
      RESP: begin
        swap_resp = 1'b1;
        install   = ev_valid;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_tag   <= '0;
      ev_valid  <= 1'b0;
      ev_dirty  <= 1'b0;
      ev_tag    <= '0;
      ev_data   <= '0;
      target    <= '0;
      swap_hit  <= 1'b0;
      swap_data <= '0;
      way_valid <= '0;
      way_dirty <= '0;
    end else begin
      unique case (state)
        IDLE: if (swap_req) begin
          req_tag  <= swap_tag;
          ev_valid <= evict_valid;
          ev_dirty <= evict_dirty;
          ev_tag   <= evict_tag;
          ev_data  <= evict_data;
        end
        LOOKUP: begin
          swap_hit <= hit;
          target   <= hit ? hit_way : victim;
          if (hit) swap_data <= way_data[hit_way];
        end
        FETCH: if (pmem_resp) swap_data <= pmem_rdata;
        RESP: begin
          way_valid[target] <= ev_valid;
          way_dirty[target] <= ev_valid & ev_dirty;
        end
        default: ;
      endcase
    end
  end

  // Line storage needs no reset; validity alone gates its use.
  always_ff @(posedge clk) begin
    if (state == RESP && ev_valid) begin
      way_tag[target]  <= ev_tag;
      way_data[target] <= ev_data;
    end
  end

  victim_lru #(.NUM_WAYS(NUM_WAYS)) u_lru (
    .clk       (clk),
    .rst       (rst),
    .touch     (install),
    .touch_way (target),
    .lru_way   (lru_way)
  );

`ifdef VICTIM_BUFFER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else if (state == LOOKUP) begin
      if (hit && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (!hit && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
      if (state_nxt == WRITEBACK && wb_count != 32'hFFFF_FFFF)
        wb_count <= wb_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_victim_buffer_control.sv
// Directed bench for victim_buffer_control with a negedge pmem responder model.
module tb_victim_buffer_control;
  import victim_buffer_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  swap_req = 1'b0;
  tag_t  swap_tag = '0;
  logic  evict_valid = 1'b0;
  logic  evict_dirty = 1'b0;
  tag_t  evict_tag = '0;
  line_t evict_data = '0;
  logic  swap_resp, swap_hit;
  line_t swap_data;
  logic  pmem_read, pmem_write;
  tag_t  pmem_addr;
  line_t pmem_wdata;
  line_t pmem_rdata = '0;
  logic  pmem_resp = 1'b0;
  logic [31:0] hit_count, miss_count, wb_count;

  int checks = 0;
  int errors = 0;

  victim_buffer_control dut (
    .clk(clk), .rst(rst),
    .swap_req(swap_req), .swap_tag(swap_tag),
    .evict_valid(evict_valid), .evict_dirty(evict_dirty),
    .evict_tag(evict_tag), .evict_data(evict_data),
    .swap_resp(swap_resp), .swap_hit(swap_hit), .swap_data(swap_data),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  // pmem model: answers after pmem_delay extra cycles of a held request
  int    pmem_delay = 0;
  line_t fetch_data = '0;
  int    pm_wait = 0, cyc = 0;
  int    rd_cyc = 0, wr_cyc = 0, resp_cnt = 0, both_hi = 0;
  int    last_rd_seq = 0, last_wr_seq = 0;
  tag_t  last_rd_addr = '0, last_wr_addr = '0;
  line_t last_wr_data = '0;

  always @(negedge clk) begin
    cyc++;
    pmem_resp = 1'b0;
    if (swap_resp) resp_cnt++;
    if (pmem_read && pmem_write) both_hi++;
    if (pmem_read) begin
      rd_cyc++;
      last_rd_addr = pmem_addr;
      last_rd_seq  = cyc;
    end
    if (pmem_write) begin
      wr_cyc++;
      last_wr_addr = pmem_addr;
      last_wr_data = pmem_wdata;
      last_wr_seq  = cyc;
    end
    if (!rst && (pmem_read || pmem_write)) begin
      if (pm_wait >= pmem_delay) begin
        pmem_resp  = 1'b1;
        pmem_rdata = fetch_data;
        pm_wait    = 0;
      end else begin
        pm_wait++;
      end
    end else begin
      pm_wait = 0;
    end
  end

  function automatic line_t mk(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_t(input string tag, input tag_t obs, input tag_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_l(input string tag, input line_t obs, input line_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_req(input tag_t t, input logic ev, input logic ed,
                           input tag_t et, input line_t d);
    step();
    swap_req    = 1'b1;
    swap_tag    = t;
    evict_valid = ev;
    evict_dirty = ed;
    evict_tag   = et;
    evict_data  = d;
  endtask

  // Returns cycles from the request cycle to swap_resp; scrambles inputs afterwards.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (lat < 200) begin
      step();
      lat++;
      if (swap_resp) break;
    end
    chk_b("resp_seen", swap_resp, 1'b1);
    swap_req    = 1'b0;
    swap_tag    = '1;
    evict_tag   = '1;
    evict_data  = '1;
    evict_valid = ~evict_valid;
    evict_dirty = ~evict_dirty;
    step();
    chk_b("resp_single", swap_resp, 1'b0);
  endtask

  int lat, rd0, wr0, rs0;

  initial begin
    step();
    step();
    rst = 1'b0;
    step();
    chk_b("rst_swap_resp", swap_resp, 1'b0);
    chk_b("rst_swap_hit", swap_hit, 1'b0);
    chk_l("rst_swap_data", swap_data, '0);
    chk_b("rst_pmem_read", pmem_read, 1'b0);
    chk_b("rst_pmem_write", pmem_write, 1'b0);
    chk_t("rst_pmem_addr", pmem_addr, '0);
    chk_n("rst_hit_count", hit_count, 32'd0);
    chk_n("rst_wb_count", wb_count, 32'd0);

    // cold miss into empty way0, fetch waits 2 extra cycles
    pmem_delay = 2;
    fetch_data = mk(8'hAA);
    rd0 = rd_cyc; wr0 = wr_cyc;
    start_req(27'h10, 1'b1, 1'b0, 27'h20, mk(8'h20));
    wait_resp(lat);
    chk_n("t1_latency", lat, 32'd5);
    chk_b("t1_hit", swap_hit, 1'b0);
    chk_l("t1_data", swap_data, mk(8'hAA));
    chk_t("t1_rd_addr", last_rd_addr, 27'h10);
    chk_n("t1_rd_cycles", rd_cyc - rd0, 32'd3);
    chk_n("t1_wr_cycles", wr_cyc - wr0, 32'd0);

    // hit on the line installed above
    pmem_delay = 0;
    rd0 = rd_cyc; wr0 = wr_cyc;
    start_req(27'h20, 1'b1, 1'b0, 27'h10, mk(8'h10));
    wait_resp(lat);
    chk_n("t2_latency", lat, 32'd2);
    chk_b("t2_hit", swap_hit, 1'b1);
    chk_l("t2_data", swap_data, mk(8'h20));
    chk_n("t2_pmem_cycles", (rd_cyc - rd0) + (wr_cyc - wr0), 32'd0);

    // fill ways 1..3 dirty, then dirty-swap way0
    fetch_data = mk(8'hF0);
    wr0 = wr_cyc;
    start_req(27'h30, 1'b1, 1'b1, 27'hA1, mk(8'hA1));
    wait_resp(lat);
    chk_n("fill1_latency", lat, 32'd3);
    start_req(27'h31, 1'b1, 1'b1, 27'hA2, mk(8'hA2));
    wait_resp(lat);
    start_req(27'h32, 1'b1, 1'b1, 27'hA3, mk(8'hA3));
    wait_resp(lat);
    chk_n("fill_no_wb", wr_cyc - wr0, 32'd0);
    start_req(27'h10, 1'b1, 1'b1, 27'hA0, mk(8'hA0));
    wait_resp(lat);
    chk_b("fill_hit0", swap_hit, 1'b1);
    chk_l("fill_hit0_data", swap_data, mk(8'h10));

    // all ways dirty: LRU is way1 (tag A1)
    fetch_data = mk(8'h99);
    rd0 = rd_cyc; wr0 = wr_cyc;
    start_req(27'h99, 1'b1, 1'b0, 27'hB0, mk(8'hB0));
    wait_resp(lat);
    chk_n("t3_latency", lat, 32'd4);
    chk_t("t3_wb_addr", last_wr_addr, 27'hA1);
    chk_l("t3_wb_data", last_wr_data, mk(8'hA1));
    chk_t("t3_rd_addr", last_rd_addr, 27'h99);
    chk_n("t3_wr_cycles", wr_cyc - wr0, 32'd1);
    chk_n("t3_rd_cycles", rd_cyc - rd0, 32'd1);
    chk_b("t3_wb_before_fetch", last_wr_seq < last_rd_seq, 1'b1);
    chk_b("t3_hit", swap_hit, 1'b0);
    chk_l("t3_data", swap_data, mk(8'h99));
`ifdef VICTIM_BUFFER_STATS_EN
    chk_n("t3_wb_count", wb_count, 32'd1);
    chk_n("t3_hit_count", hit_count, 32'd2);
    chk_n("t3_miss_count", miss_count, 32'd5);
`else
    chk_n("t3_wb_count", wb_count, 32'd0);
    chk_n("t3_hit_count", hit_count, 32'd0);
    chk_n("t3_miss_count", miss_count, 32'd0);
`endif

    // evict line captured at request time, not the scrambled inputs
    start_req(27'hB0, 1'b1, 1'b0, 27'hB1, mk(8'hB1));
    wait_resp(lat);
    chk_b("t3b_hit", swap_hit, 1'b1);
    chk_l("t3b_data", swap_data, mk(8'hB0));

    // slow pmem, no evict line: way2 (A2) written back then invalidated
    pmem_delay = 5;
    fetch_data = mk(8'h55);
    rd0 = rd_cyc; wr0 = wr_cyc; rs0 = resp_cnt;
    start_req(27'h55, 1'b0, 1'b1, 27'hEE, mk(8'hEE));
    wait_resp(lat);
    chk_n("t4_latency", lat, 32'd14);
    chk_n("t4_wr_cycles", wr_cyc - wr0, 32'd6);
    chk_n("t4_rd_cycles", rd_cyc - rd0, 32'd6);
    chk_n("t4_resp_count", resp_cnt - rs0, 32'd1);
    chk_t("t4_wb_addr", last_wr_addr, 27'hA2);
    chk_l("t4_data", swap_data, mk(8'h55));

    // miss into invalidated way2 goes straight to FETCH; reset mid-FETCH
    pmem_delay = 20;
    wr0 = wr_cyc;
    start_req(27'h66, 1'b1, 1'b0, 27'hC0, mk(8'hC0));
    for (int i = 0; i < 10; i++) begin
      step();
      if (pmem_read) break;
    end
    chk_b("t5_in_fetch", pmem_read, 1'b1);
    chk_t("t5_rd_addr", pmem_addr, 27'h66);
    chk_n("t5_no_wb", wr_cyc - wr0, 32'd0);
    rs0 = resp_cnt;
    rst = 1'b1;
    #1;
    chk_b("t5_rst_read", pmem_read, 1'b0);
    chk_b("t5_rst_write", pmem_write, 1'b0);
    chk_b("t5_rst_resp", swap_resp, 1'b0);
    swap_req = 1'b0;
    step();
    rst = 1'b0;
    repeat (5) step();
    chk_n("t5_no_resp", resp_cnt - rs0, 32'd0);
    chk_n("t5_wb_count", wb_count, 32'd0);

    // former dirty way0 (A0) is gone: plain miss, no writeback
    pmem_delay = 0;
    fetch_data = mk(8'h77);
    rd0 = rd_cyc; wr0 = wr_cyc;
    start_req(27'hA0, 1'b0, 1'b0, 27'h0, mk(8'h00));
    wait_resp(lat);
    chk_n("t6_latency", lat, 32'd3);
    chk_b("t6_hit", swap_hit, 1'b0);
    chk_t("t6_rd_addr", last_rd_addr, 27'hA0);
    chk_n("t6_wr_cycles", wr_cyc - wr0, 32'd0);
`ifdef VICTIM_BUFFER_STATS_EN
    chk_n("t6_miss_count", miss_count, 32'd1);
`else
    chk_n("t6_miss_count", miss_count, 32'd0);
`endif

    chk_n("read_write_overlap", both_hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
